// File: rtl/shift_add_mult.sv
// Radix-2 shift-add multiplier, signed/unsigned, full 2*WIDTH product.
// Latency: done pulses k+2 cycles after accept (k = bit length of |b_in|), at most WIDTH+2.
// Backpressure: none; start is only honoured in IDLE, ignored while busy.
module shift_add_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic                 neg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // The most-negative operand negates to 2^(WIDTH-1), which still fits as unsigned.
    always_comb begin
        a_mag = a_in;
        b_mag = b_in;
        if (signed_mode && a_in[WIDTH-1]) begin
            a_mag = ~a_in + ONE_W;
        end
        if (signed_mode && b_in[WIDTH-1]) begin
            b_mag = ~b_in + ONE_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        neg    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Stop as soon as the remaining multiplier bits are all zero.
                    if (mplier != '0) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        product <= neg ? (~acc + ONE_P) : acc;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized and directed check of shift_add_mult against an arithmetic reference model.
module tb_shift_add_mult;

    localparam int WIDTH = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_checks;
    int n_fail;

    shift_add_mult #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer product of the interpreted operands, latency from |b| bit length.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                         output logic [2*WIDTH-1:0] exp_p, output int exp_lat);
        longint sa, sb, mb, p;
        int k;
        sa = sm ? longint'($signed(a)) : longint'(a);
        sb = sm ? longint'($signed(b)) : longint'(b);
        p = sa * sb;
        exp_p = p[2*WIDTH-1:0];
        mb = (sb < 0) ? -sb : sb;
        k = 0;
        while ((mb >> k) != 0) k++;
        exp_lat = k + 2;
    endtask

    // extra_cyc: cycle after accept in which start is raised again (0 = never).
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                          input int extra_cyc, input string tag);
        logic [2*WIDTH-1:0] exp_p;
        logic [2*WIDTH-1:0] got_p;
        int exp_lat;
        int got_lat;
        model(a, b, sm, exp_p, exp_lat);
        @(negedge clk);
        a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); signed_mode = 1'($urandom);
        got_lat = 0;
        got_p = '0;
        for (int c = 1; c <= WIDTH + 4 && got_lat == 0; c++) begin
            @(negedge clk);
            if (done) begin
                got_lat = c;
                got_p = product;
                check_eq({tag, ":busy_at_done"}, 64'(busy), 64'd1);
            end else begin
                check_eq({tag, ":busy_run"}, 64'(busy), 64'd1);
            end
            start = (c == extra_cyc);
        end
        check_eq({tag, ":latency"}, 64'(got_lat), 64'(exp_lat));
        check_eq({tag, ":product"}, 64'(got_p), 64'(exp_p));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, ":busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, ":done_after"}, 64'(done), 64'd0);
        check_eq({tag, ":product_hold"}, 64'(product), 64'(exp_p));
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return WIDTH'(1);
            2: return {1'b0, {(WIDTH-1){1'b1}}};
            3: return {1'b1, {(WIDTH-1){1'b0}}};
            4: return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        int seen_done;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset:busy", 64'(busy), 64'd0);
        check_eq("reset:done", 64'(done), 64'd0);
        check_eq("reset:product", 64'(product), 64'd0);
        rst = 1'b0;

        run_op(16'd3, 16'd5, 1'b0, 0, "u_3x5");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, "u_max");
        run_op(16'hFFFD, 16'd5, 1'b1, 0, "s_m3x5");
        run_op(16'h8000, 16'h8000, 1'b1, 0, "s_minxmin");
        run_op(16'hFFFB, 16'd0, 1'b1, 1, "s_zero_b");
        run_op(16'd9, 16'd6, 1'b0, 5, "start_in_done");
        run_op(16'h1234, 16'hFFFF, 1'b1, 0, "s_by_m1");

        // Reset aborts an operation in flight with no done pulse.
        @(negedge clk);
        a_in = 16'd7; b_in = 16'h00FF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen_done = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid:busy", 64'(busy), 64'd0);
        check_eq("rst_mid:done", 64'(done), 64'd0);
        check_eq("rst_mid:product", 64'(product), 64'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check_eq("rst_mid:no_done", 64'(seen_done), 64'd0);
        run_op(16'd2, 16'd2, 1'b0, 0, "after_rst_2x2");

        for (int i = 0; i < 200; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
